seg7_reader: RTL and testbench
==============================

SEG7_READER -- requirements
Module: seg7_reader

Interface
REQ-001 Parameter STABLE, default 4, SHALL set the number of consecutive identical samples required to accept a pattern (legal 1..255).
REQ-002 CLK  input  1  SHALL be the single clock; all state SHALL update on its rising edge.
REQ-003 RST  input  1  SHALL be a synchronous, active-high reset sampled on the rising edge of CLK.
REQ-004 SEG  input  7  SHALL carry the active-low segment pattern, bit0=a ... bit6=g (0 = segment lit).
REQ-005 HEX  output 4  SHALL hold the last accepted hex digit.
REQ-006 VALID  output 1  SHALL be high while HEX reflects the currently accepted legal pattern.
REQ-007 NEW  output 1  SHALL pulse high for one cycle when a new legal digit is accepted.
REQ-008 ERR  output 1  SHALL pulse high for one cycle when an illegal pattern is accepted.
REQ-009 BLANK  output 1  SHALL be high while the accepted pattern is all-off (7'h7F).

Function
REQ-010 SEG SHALL be registered into seg_q every cycle; all qualification SHALL use seg_q only.
REQ-011 Legal font (hex value: SEG) SHALL be exactly: 0:40 1:79 2:24 3:30 4:19 5:12 6:02 7:78 8:00 9:18 A:08 b:03 C:46 d:21 E:06 F:0E.
REQ-012 Any other pattern except 7F SHALL be illegal.
REQ-013 The FSM SHALL have states IDLE, QUAL, LOCK.
REQ-014 IDLE: on any seg_q sample, load cand<=seg_q, cnt<=1, go to QUAL (if STABLE=1, accept in the same cycle).
REQ-015 QUAL: seg_q==cand increments cnt; seg_q!=cand reloads cand<=seg_q, cnt<=1, stays in QUAL.
REQ-016 Acceptance SHALL occur on the cycle cnt reaches STABLE; the FSM SHALL then enter LOCK and latch acc<=cand.
REQ-017 LOCK: seg_q==acc holds; seg_q!=acc reloads cand/cnt=1 and enters QUAL; outputs SHALL hold during requalification.
REQ-018 cnt SHALL be 8 bits and SHALL saturate at STABLE, never wrapping.
REQ-019 Latency: SEG held constant from edge k SHALL produce NEW high in the cycle after edge k+STABLE (STABLE+1 edges).
REQ-020 On accepting a legal pattern: HEX<=decoded value, VALID<=1, BLANK<=0; NEW<=1 only if the pattern differs from the previously accepted pattern or VALID was 0.
REQ-021 A glitch that returns to acc before acceptance SHALL produce no NEW, ERR or output change.
REQ-022 On accepting 7F: VALID<=0, BLANK<=1, HEX held, NEW=0, ERR=0.
REQ-023 On accepting an illegal pattern: VALID<=0, BLANK<=0, HEX held, ERR=1 for one cycle; re-accepting the same illegal pattern without an intervening different acceptance SHALL NOT re-pulse ERR.
REQ-024 NEW and ERR SHALL never be high in the same cycle.

Reset
REQ-025 With RST high on an edge: state<=IDLE, seg_q<=7F, cand<=7F, acc<=7F, cnt<=0, HEX<=0, VALID<=0, NEW<=0, ERR<=0, BLANK<=0.
REQ-026 RST SHALL override all activity including mid-qualification; no pulse SHALL be emitted in the reset cycle or the cycle after.

Verification
REQ-027 STABLE=4, reset, SEG=7'h30 held -> NEW=1, HEX=3, VALID=1 exactly 5 edges after SEG applied; NEW low the next cycle.
REQ-028 Locked on 3, SEG=7'h12 for 2 cycles then back to 7'h30 -> no NEW/ERR; HEX stays 3, VALID stays 1.
REQ-029 Locked on 3, SEG=7'h7F held -> BLANK=1, VALID=0, HEX=3, no NEW/ERR; then SEG=7'h30 -> NEW=1, VALID=1.
REQ-030 SEG=7'h55 (illegal) held -> ERR one-cycle pulse, VALID=0, HEX unchanged; still held -> no further ERR.
REQ-031 Sweep all 16 legal codes with STABLE=1 -> each produces NEW with HEX 0..F in order, 2 edges after its SEG.
REQ-032 RST asserted at cnt=3 of a qualification -> all outputs 0 next cycle; qualification restarts from cnt=1 after release.

Source files
------------

// File: rtl/seg7_reader.sv
`default_nettype none
// ============================================================================
//  Module      : seg7_reader
//  Description : Reads an active-low 7-segment pattern and debounces it.
//                A pattern is accepted once it has been sampled STABLE times
//                in a row. Legal font patterns are decoded to a hex digit.
//                The all-off pattern reports BLANK. Any other pattern is
//                illegal and raises a one-cycle ERR pulse.
//  Ports       : CLK   - single clock, rising edge
//                RST   - synchronous active-high reset
//                SEG   - active-low segments, bit0 = a ... bit6 = g
//                HEX   - last accepted legal digit
//                VALID - HEX reflects the currently accepted legal pattern
//                NEW   - one-cycle pulse on acceptance of a new legal digit
//                ERR   - one-cycle pulse on acceptance of an illegal pattern
//                BLANK - accepted pattern is all-off (7'h7F)
//  Revision    : 1.0 - initial release
// ============================================================================
module seg7_reader #(
    parameter int STABLE = 4
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic [6:0] SEG,
    output logic [3:0] HEX,
    output logic       VALID,
    output logic       NEW,
    output logic       ERR,
    output logic       BLANK
);

    localparam logic [7:0] c_stable = 8'(STABLE);
    localparam logic [6:0] c_blank  = 7'h7F;

    generate
        if (STABLE < 1 || STABLE > 255) begin : g_stable_range
            $error("seg7_reader: STABLE must be in 1..255");
        end
    endgenerate

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_QUAL = 2'd1,
        S_LOCK = 2'd2
    } state_t;

    state_t      r_state, w_state_d;
    logic [6:0]  r_seg_q;
    logic [6:0]  r_cand, w_cand_d;
    logic [6:0]  r_acc,  w_acc_d;
    logic [7:0]  r_cnt,  w_cnt_d;
    logic [3:0]  r_hex,  w_hex_d;
    logic        r_valid, w_valid_d;
    logic        r_new,   w_new_d;
    logic        r_err,   w_err_d;
    logic        r_blank, w_blank_d;
    logic        w_accept;
    logic [4:0]  w_dec;

    // Returns {legal, digit}; legal is 0 for every non-font pattern.
    function automatic logic [4:0] f_decode(input logic [6:0] pat);
        case (pat)
            7'h40:   f_decode = 5'h10;
            7'h79:   f_decode = 5'h11;
            7'h24:   f_decode = 5'h12;
            7'h30:   f_decode = 5'h13;
            7'h19:   f_decode = 5'h14;
            7'h12:   f_decode = 5'h15;
            7'h02:   f_decode = 5'h16;
            7'h78:   f_decode = 5'h17;
            7'h00:   f_decode = 5'h18;
            7'h18:   f_decode = 5'h19;
            7'h08:   f_decode = 5'h1A;
            7'h03:   f_decode = 5'h1B;
            7'h46:   f_decode = 5'h1C;
            7'h21:   f_decode = 5'h1D;
            7'h06:   f_decode = 5'h1E;
            7'h0E:   f_decode = 5'h1F;
            default: f_decode = 5'h00;
        endcase
    endfunction

    // Next-state and output logic. Acceptance is evaluated on the count the
    // register is about to take, so NEW/ERR appear right after the edge on
    // which the count reaches STABLE.
    always_comb begin
        w_state_d = r_state;
        w_cand_d  = r_cand;
        w_cnt_d   = r_cnt;
        w_acc_d   = r_acc;
        w_accept  = 1'b0;
        w_hex_d   = r_hex;
        w_valid_d = r_valid;
        w_blank_d = r_blank;
        w_new_d   = 1'b0;
        w_err_d   = 1'b0;

        case (r_state)
            S_IDLE: begin
                w_cand_d  = r_seg_q;
                w_cnt_d   = 8'd1;
                w_state_d = S_QUAL;
            end
            S_QUAL: begin
                if (r_seg_q == r_cand) begin
                    // Saturating count; never wraps past STABLE.
                    w_cnt_d = (r_cnt < c_stable) ? r_cnt + 8'd1 : r_cnt;
                end else begin
                    w_cand_d = r_seg_q;
                    w_cnt_d  = 8'd1;
                end
            end
            S_LOCK: begin
                if (r_seg_q != r_acc) begin
                    w_cand_d  = r_seg_q;
                    w_cnt_d   = 8'd1;
                    w_state_d = S_QUAL;
                end
            end
            default: begin
                w_state_d = S_IDLE;
                w_cnt_d   = 8'd0;
            end
        endcase

        // A held LOCK keeps cnt at STABLE but is not a fresh acceptance.
        w_accept = (w_state_d == S_QUAL) && (w_cnt_d == c_stable);
        w_dec    = f_decode(w_cand_d);

        if (w_accept) begin
            w_state_d = S_LOCK;
            w_acc_d   = w_cand_d;
            if (w_dec[4]) begin
                w_hex_d   = w_dec[3:0];
                w_valid_d = 1'b1;
                w_blank_d = 1'b0;
                w_new_d   = (w_cand_d != r_acc) || !r_valid;
            end else if (w_cand_d == c_blank) begin
                w_valid_d = 1'b0;
                w_blank_d = 1'b1;
            end else begin
                w_valid_d = 1'b0;
                w_blank_d = 1'b0;
                // Re-accepting the same illegal pattern stays quiet.
                w_err_d   = (w_cand_d != r_acc);
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state <= S_IDLE;
            r_seg_q <= c_blank;
            r_cand  <= c_blank;
            r_acc   <= c_blank;
            r_cnt   <= 8'd0;
            r_hex   <= 4'd0;
            r_valid <= 1'b0;
            r_new   <= 1'b0;
            r_err   <= 1'b0;
            r_blank <= 1'b0;
        end else begin
            r_state <= w_state_d;
            r_seg_q <= SEG;
            r_cand  <= w_cand_d;
            r_acc   <= w_acc_d;
            r_cnt   <= w_cnt_d;
            r_hex   <= w_hex_d;
            r_valid <= w_valid_d;
            r_new   <= w_new_d;
            r_err   <= w_err_d;
            r_blank <= w_blank_d;
        end
    end

    assign HEX   = r_hex;
    assign VALID = r_valid;
    assign NEW   = r_new;
    assign ERR   = r_err;
    assign BLANK = r_blank;

endmodule
`default_nettype wire

// File: tb/tb_seg7_reader.sv
`default_nettype none
// ============================================================================
//  Module      : tb_seg7_reader
//  Description : Self-checking bench for seg7_reader. Two instances run side
//                by side (STABLE=4 and STABLE=1) against a history-based
//                model, plus directed literal checks.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_seg7_reader;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [6:0] seg4 = 7'h7F;
    logic [6:0] seg1 = 7'h7F;
    logic [3:0] hex4, hex1;
    logic       valid4, new4, err4, blank4;
    logic       valid1, new1, err1, blank1;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    seg7_reader #(.STABLE(4)) dut4 (
        .CLK(clk), .RST(rst), .SEG(seg4),
        .HEX(hex4), .VALID(valid4), .NEW(new4), .ERR(err4), .BLANK(blank4)
    );

    seg7_reader #(.STABLE(1)) dut1 (
        .CLK(clk), .RST(rst), .SEG(seg1),
        .HEX(hex1), .VALID(valid1), .NEW(new1), .ERR(err1), .BLANK(blank1)
    );

    // Font table: index is the digit value.
    logic [6:0] font [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                              7'h00, 7'h18, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Model: a pattern is accepted exactly when the last STABLE observed
    // samples are identical and the sample before them (if any since
    // reset) was different. Observed sample = SEG from the previous edge,
    // or 7F on the first edge after reset.
    // ------------------------------------------------------------------
    int         m_stable [2] = '{4, 1};
    logic [6:0] m_pipe   [2];
    logic [6:0] m_hist   [2][16];
    int         m_hn     [2];
    logic [6:0] m_acc    [2];
    logic [3:0] m_hex    [2];
    logic       m_valid  [2], m_new [2], m_err [2], m_blank [2];

    always @(posedge clk) begin
        logic [6:0] s;
        logic [6:0] p;
        logic       acc_ok;
        int         st;
        int         idx;
        for (int d = 0; d < 2; d++) begin
            s  = (d == 0) ? seg4 : seg1;
            st = m_stable[d];
            if (rst) begin
                m_pipe[d] = 7'h7F; m_hn[d] = 0; m_acc[d] = 7'h7F;
                m_hex[d] = 4'd0; m_valid[d] = 0; m_new[d] = 0;
                m_err[d] = 0; m_blank[d] = 0;
            end else begin
                for (int k = 15; k > 0; k--) m_hist[d][k] = m_hist[d][k-1];
                m_hist[d][0] = m_pipe[d];
                if (m_hn[d] < 16) m_hn[d]++;
                m_pipe[d] = s;
                m_new[d] = 0; m_err[d] = 0;
                acc_ok = (m_hn[d] >= st);
                for (int k = 1; k < st; k++)
                    if (acc_ok && m_hist[d][k] != m_hist[d][0]) acc_ok = 0;
                if (acc_ok && m_hn[d] > st && m_hist[d][st] == m_hist[d][0]) acc_ok = 0;
                if (acc_ok) begin
                    p = m_hist[d][0];
                    idx = -1;
                    for (int k = 0; k < 16; k++) if (font[k] == p) idx = k;
                    if (idx >= 0) begin
                        m_new[d] = (p != m_acc[d]) || !m_valid[d];
                        m_hex[d] = 4'(idx); m_valid[d] = 1; m_blank[d] = 0;
                    end else if (p == 7'h7F) begin
                        m_valid[d] = 0; m_blank[d] = 1;
                    end else begin
                        m_err[d] = (p != m_acc[d]); m_valid[d] = 0; m_blank[d] = 0;
                    end
                    m_acc[d] = p;
                end
            end
        end
        #1;
        check("m4.hex",   32'(hex4),   32'(m_hex[0]));
        check("m4.valid", 32'(valid4), 32'(m_valid[0]));
        check("m4.new",   32'(new4),   32'(m_new[0]));
        check("m4.err",   32'(err4),   32'(m_err[0]));
        check("m4.blank", 32'(blank4), 32'(m_blank[0]));
        check("m4.excl",  32'(new4 & err4), 32'd0);
        check("m1.hex",   32'(hex1),   32'(m_hex[1]));
        check("m1.valid", 32'(valid1), 32'(m_valid[1]));
        check("m1.new",   32'(new1),   32'(m_new[1]));
        check("m1.err",   32'(err1),   32'(m_err[1]));
        check("m1.blank", 32'(blank1), 32'(m_blank[1]));
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    // ------------------------------------------------------------------
    // Directed stimulus with hand-computed literal expectations.
    // ------------------------------------------------------------------
    initial begin
        int err_seen;
        tick(3);
        check("rst.hex",   32'(hex4),   32'd0);
        check("rst.valid", 32'(valid4), 32'd0);
        check("rst.new",   32'(new4),   32'd0);
        check("rst.blank", 32'(blank4), 32'd0);

        // Digit 3 held from reset release: NEW on the 5th edge.
        rst = 1'b0; seg4 = 7'h30;
        tick(4);
        check("d3.early_new", 32'(new4), 32'd0);
        tick(1);
        check("d3.new",   32'(new4),   32'd1);
        check("d3.hex",   32'(hex4),   32'd3);
        check("d3.valid", 32'(valid4), 32'd1);
        tick(1);
        check("d3.new_drop", 32'(new4), 32'd0);
        tick(2);

        // Two-cycle glitch back to the locked pattern.
        seg4 = 7'h12; tick(2); seg4 = 7'h30;
        for (int i = 0; i < 8; i++) begin
            tick(1);
            check("glitch.hex",   32'(hex4),   32'd3);
            check("glitch.valid", 32'(valid4), 32'd1);
            check("glitch.pulse", 32'(new4 | err4), 32'd0);
        end

        // Blank then the digit again.
        seg4 = 7'h7F; tick(6);
        check("blank.blank", 32'(blank4), 32'd1);
        check("blank.valid", 32'(valid4), 32'd0);
        check("blank.hex",   32'(hex4),   32'd3);
        seg4 = 7'h30; tick(4);
        check("reblank.early", 32'(new4), 32'd0);
        tick(1);
        check("reblank.new",   32'(new4),   32'd1);
        check("reblank.valid", 32'(valid4), 32'd1);
        tick(2);

        // Illegal pattern.
        seg4 = 7'h55; tick(5);
        check("ill.err",   32'(err4),   32'd1);
        check("ill.valid", 32'(valid4), 32'd0);
        check("ill.hex",   32'(hex4),   32'd3);
        tick(1);
        check("ill.err_drop", 32'(err4), 32'd0);
        err_seen = 0;
        for (int i = 0; i < 10; i++) begin tick(1); err_seen += int'(err4); end
        seg4 = 7'h12; tick(1); seg4 = 7'h55;
        for (int i = 0; i < 10; i++) begin tick(1); err_seen += int'(err4); end
        check("ill.no_repulse", 32'(err_seen), 32'd0);

        // STABLE=1 sweep of all 16 digits.
        for (int i = 0; i < 16; i++) begin
            seg1 = font[i];
            tick(1);
            check("sweep.early", 32'(new1), 32'd0);
            tick(1);
            check($sformatf("sweep%0d.new", i), 32'(new1), 32'd1);
            check($sformatf("sweep%0d.hex", i), 32'(hex1), 32'(i));
        end

        // Reset in the middle of a qualification (cnt=3).
        seg4 = 7'h06; tick(4);
        rst = 1'b1; tick(1);
        check("mid.hex",   32'(hex4),   32'd0);
        check("mid.valid", 32'(valid4), 32'd0);
        check("mid.blank", 32'(blank4), 32'd0);
        check("mid.pulse", 32'(new4 | err4), 32'd0);
        rst = 1'b0; tick(1);
        check("mid.after", 32'(new4 | err4 | new1 | err1), 32'd0);
        tick(3);
        check("mid.early", 32'(new4), 32'd0);
        tick(1);
        check("mid.new", 32'(new4), 32'd1);
        check("mid.hex", 32'(hex4), 32'hE);
        tick(3);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
